// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: enable, mode and data inputs, plus the
// registered q/tc/chg outputs.
interface jk_reg_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic [WIDTH-1:0] chg;

  modport master (
    output en, mode, j, k, d,
    input  q, tc, chg
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, tc, chg
  );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flops with per-bit JK, up/down count and parallel load modes.
// Optional JK_BANK_CHG_EN macro adds registered per-bit change flags on chg.
module jk_reg_bank #(
  parameter int unsigned     WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  jk_reg_bank_if.slave bus
);

  localparam logic [1:0] ModeJk   = 2'b00;
  localparam logic [1:0] ModeUp   = 2'b01;
  localparam logic [1:0] ModeDown = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] j_eff, k_eff;

  // Toggle cascade: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_q[i-1];
      dn_t[i] = dn_t[i-1] & ~q_q[i-1];
    end
  end

  // Every mode is expressed as per-bit J/K so all bits share one JK equation;
  // inputs unused by the selected mode never reach j_eff/k_eff.
  always_comb begin
    j_eff = '0;
    k_eff = '0;
    tc_d  = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        ModeJk: begin
          j_eff = bus.j;
          k_eff = bus.k;
        end
        ModeUp: begin
          j_eff = up_t;
          k_eff = up_t;
          tc_d  = &q_q;
        end
        ModeDown: begin
          j_eff = dn_t;
          k_eff = dn_t;
          tc_d  = ~|q_q;
        end
        ModeLoad: begin
          j_eff = bus.d;
          k_eff = ~bus.d;
        end
      endcase
    end
    q_d = (j_eff & ~q_q) | (~k_eff & q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= RST_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.tc = tc_q;

`ifdef JK_BANK_CHG_EN
  logic [WIDTH-1:0] chg_q, chg_d;

  // With en=0 q_d equals q_q, so the XOR already yields zero.
  always_comb begin
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign bus.chg = chg_q;
`else
  assign bus.chg = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4, RST_VAL=0); expected chg follows
// JK_BANK_CHG_EN when the bench is compiled with the same macro as the RTL.
module tb_jk_reg_bank;

`ifdef JK_BANK_CHG_EN
  localparam bit ChgEn = 1'b1;
`else
  localparam bit ChgEn = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic [3:0] chg;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  jk_reg_bank_if #(.WIDTH(4)) bus ();

  jk_reg_bank #(
    .WIDTH  (4),
    .RST_VAL(4'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_prev = 4'h0;
  event       async_chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input logic [3:0] eq, input logic et, input logic [3:0] ech,
                                   input string nm);
    exp_t e;
    e.q   = eq;
    e.tc  = et;
    e.chg = ChgEn ? ech : 4'h0;
    e.nm  = nm;
    sb.push_back(e);
  endfunction

  // Drive one cycle of inputs at the negedge and queue the response for the next edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] jj,
                      input logic [3:0] kk, input logic [3:0] dd, input logic [3:0] eq,
                      input logic et, input string nm);
    @(negedge clk);
    bus.en   = e;
    bus.mode = m;
    bus.j    = jj;
    bus.k    = kk;
    bus.d    = dd;
    push_exp(eq, et, eq ^ exp_prev, nm);
    exp_prev = eq;
  endtask

  // Monitor: drains the scoreboard 1 unit after each edge or async check request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_chk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 3;
        if (bus.q !== e.q) begin
          errors++;
          $display("FAIL %s q: got %h expected %h", e.nm, bus.q, e.q);
        end
        if (bus.tc !== e.tc) begin
          errors++;
          $display("FAIL %s tc: got %b expected %b", e.nm, bus.tc, e.tc);
        end
        if (bus.chg !== e.chg) begin
          errors++;
          $display("FAIL %s chg: got %h expected %h", e.nm, bus.chg, e.chg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = 2'b00;
    bus.j    = 4'h0;
    bus.k    = 4'h0;
    bus.d    = 4'h0;

    #2;
    push_exp(4'h0, 1'b0, 4'h0, "reset_init");
    -> async_chk;
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges
    step(1'b1, 2'b11, 4'h0, 4'h0, 4'hA, 4'hA, 1'b0, "load_a");
    @(negedge clk);
    #2;
    rst    = 1'b1;
    bus.en = 1'b0;
    #1;
    push_exp(4'h0, 1'b0, 4'h0, "async_rst");
    exp_prev = 4'h0;
    -> async_chk;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b11, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, "rst_release");

    // JK mode
    step(1'b1, 2'b00, 4'b1100, 4'b0011, 4'hF, 4'b1100, 1'b0, "jk_set_clr");
    step(1'b1, 2'b00, 4'b1010, 4'b1010, 4'h0, 4'b0110, 1'b0, "jk_toggle");
    step(1'b1, 2'b00, 4'b0000, 4'b0000, 4'hF, 4'b0110, 1'b0, "jk_hold");
    step(1'b1, 2'b00, 4'b0000, 4'b1111, 4'hF, 4'b0000, 1'b0, "jk_clear");

    // Up count with wrap
    step(1'b1, 2'b11, 4'h0, 4'h0, 4'hE, 4'hE, 1'b0, "load_e");
    step(1'b1, 2'b01, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, "up_f");
    step(1'b1, 2'b01, 4'hF, 4'h0, 4'h5, 4'h0, 1'b1, "up_wrap");
    step(1'b1, 2'b01, 4'h0, 4'hF, 4'h5, 4'h1, 1'b0, "up_1");

    // Down count with wrap, then enable low
    step(1'b1, 2'b11, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, "load_1");
    step(1'b1, 2'b10, 4'hF, 4'hF, 4'h9, 4'h0, 1'b0, "down_0");
    step(1'b1, 2'b10, 4'h0, 4'h0, 4'h9, 4'hF, 1'b1, "down_wrap");
    step(1'b1, 2'b10, 4'h3, 4'hC, 4'h9, 4'hE, 1'b0, "down_e");
    step(1'b0, 2'b11, 4'hF, 4'h0, 4'h3, 4'hE, 1'b0, "en_low_1");
    step(1'b0, 2'b01, 4'hF, 4'hF, 4'h3, 4'hE, 1'b0, "en_low_2");

    // Reset mid-count
    step(1'b1, 2'b11, 4'h0, 4'h0, 4'h6, 4'h6, 1'b0, "load_6");
    step(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h7, 1'b0, "up_7");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push_exp(4'h0, 1'b0, 4'h0, "mid_count_rst");
    exp_prev = 4'h0;
    -> async_chk;
    #2;
    rst = 1'b0;
    push_exp(4'h1, 1'b0, 4'h1, "resume_1");
    exp_prev = 4'h1;
    step(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, "resume_2");

    // Change flags
    step(1'b1, 2'b11, 4'h0, 4'h0, 4'b0110, 4'b0110, 1'b0, "load_6b");
    step(1'b1, 2'b00, 4'b0011, 4'b0011, 4'h0, 4'b0101, 1'b0, "chg_toggle");
    step(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'b0101, 1'b0, "chg_idle");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
